// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the serially loaded 16 x 5 lookup memory.
package mem_pkg;

    localparam int DW    = 5;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // Loader sequencing: wait, shift bits in, commit one word, announce completion.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : mem_pkg

// File: rtl/mem_array.sv
// Storage for the lookup memory: one synchronous write port and one registered,
// enabled read port. Contents survive reset; only the read register is cleared.
module mem_array
    import mem_pkg::*;
#(
    parameter int DW    = mem_pkg::DW,
    parameter int AW    = mem_pkg::AW,
    parameter int DEPTH = mem_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    // Commit a word; the array is deliberately not reset so a reset mid-load keeps earlier words.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read; sampling the array before the same-edge write gives read-before-write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (en) begin
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule : mem_array

// File: rtl/rom_loader.sv
// Serial programming engine for the lookup memory: assembles MSB-first bit-serial
// words and writes them to addresses 0..DEPTH-1 in order, while keeping the
// existing registered read port available at all times.
module rom_loader
    import mem_pkg::*;
#(
    parameter int DW    = mem_pkg::DW,
    parameter int AW    = mem_pkg::AW,
    parameter int DEPTH = mem_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sin,
    input  logic          sin_valid,
    output logic          sin_ready,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] addr,
    input  logic          en,
    output logic [DW-1:0] dout
);

    localparam int BCW = $clog2(DW);

    state_t          r_state;
    logic [BCW-1:0]  r_bit_cnt;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_shreg;
    logic            r_sin_ready;
    logic            r_busy;
    logic            r_done;

    logic            w_xfer;
    logic            w_we;

    // A bit moves only when the loader advertises ready; ready is a pure state decode.
    assign w_xfer = sin_valid & r_sin_ready;
    // The write strobe is a decode of the WRITE state, so the word is committed at the end of that cycle.
    assign w_we   = (r_state == WRITE);

    // Loader FSM with shift register, counters and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_waddr     <= '0;
            r_shreg     <= '0;
            r_sin_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= LOAD;
                        r_bit_cnt   <= '0;
                        r_waddr     <= '0;
                        r_sin_ready <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_shreg   <= {r_shreg[DW-2:0], sin};
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        if (r_bit_cnt == BCW'(DW - 1)) begin
                            // Drop ready in the same edge so the WRITE cycle consumes no bit.
                            r_state     <= WRITE;
                            r_sin_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    r_bit_cnt <= '0;
                    if (r_waddr == AW'(DEPTH - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_waddr     <= r_waddr + AW'(1);
                        r_state     <= LOAD;
                        r_sin_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_waddr <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_sin_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign sin_ready = r_sin_ready;
    assign busy      = r_busy;
    assign done      = r_done;

    mem_array #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (r_waddr),
        .wdata (r_shreg),
        .en    (en),
        .addr  (addr),
        .dout  (dout)
    );

endmodule : rom_loader

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: randomized images and stall gaps, a memory
// model updated per completed load, and a monitor that checks read data and the
// done pulse cycle against queued expectations.
module tb_rom_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       en = 1'b0;
    logic [3:0] addr = 4'd0;
    logic       sin_ready;
    logic       busy;
    logic       done;
    logic [4:0] dout;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       rd_vld_d = 1'b0;

    logic [4:0] model [16];
    logic [4:0] img [16];
    logic       gap_at [80];
    logic [4:0] exp_q [$];
    int         done_q [$];
    logic [4:0] mon_rd;
    int         mon_dc;

    rom_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sin_ready (sin_ready),
        .busy      (busy),
        .done      (done),
        .addr      (addr),
        .en        (en),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and read-valid pipeline (read data appears one edge after en).
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_vld_d <= en;
    end

    // Monitor: pop and compare whenever the DUT presents read data or a done pulse.
    always @(negedge clk) begin
        if (rd_vld_d) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                mon_rd = exp_q.pop_front();
                check("rd_data", int'(dout), int'(mon_rd));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                mon_dc = done_q.pop_front();
                check("done_cycle", cyc, mon_dc);
            end
        end
    end

    task automatic wait_done();
        for (int t = 0; t < 40 && done_q.size() != 0; t++) @(posedge clk);
        if (done_q.size() != 0) begin
            check("done_missing", 0, 1);
            done_q.delete();
        end
        #1;
    endtask

    // Stream img MSB-first; gaps of 3 idle cycles inside words; optional start pulse; optional early stop.
    task automatic load(input int ngaps, input int pulse_bit, input int stop_bits);
        int  total_gap;
        int  s;
        int  w;
        bit  ok;
        bit  rdy;
        for (int i = 0; i < 80; i++) gap_at[i] = 1'b0;
        for (int g = 0; g < ngaps; g++) begin
            int p;
            p = int'($urandom_range(79, 1));
            if (p % 5 == 0) p = p - 1;
            gap_at[p] = 1'b1;
        end
        total_gap = 0;
        for (int i = 0; i < 80; i++) if (gap_at[i]) total_gap += 3;
        start = 1'b1;
        s = cyc;
        if (stop_bits == 80) done_q.push_back(s + 97 + total_gap);
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < stop_bits; b++) begin
            if (gap_at[b]) begin
                sin_valid = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
            end
            w = b / 5;
            sin = img[w][4 - (b % 5)];
            sin_valid = 1'b1;
            start = (b == pulse_bit);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                rdy = sin_ready;
                @(posedge clk); #1;
                ok = rdy;
            end
            if (!ok) begin
                check("sin_ready_timeout", 0, 1);
                sin_valid = 1'b0;
                start = 1'b0;
                done_q.delete();
                return;
            end
        end
        sin_valid = 1'b0;
        start = 1'b0;
        if (stop_bits == 80) begin
            for (int i = 0; i < 16; i++) model[i] = img[i];
            wait_done();
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            en = 1'b1;
            addr = 4'(i);
            exp_q.push_back(model[i]);
            @(posedge clk); #1;
        end
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 5'd0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_busy", int'(busy), 0);
        check("rst_sin_ready", int'(sin_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_dout", int'(dout), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous stream of i ^ 10101, then an immediate back-to-back reload with gaps.
        for (int i = 0; i < 16; i++) img[i] = 5'(i) ^ 5'b10101;
        load(0, -1, 80);
        load(4, -1, 80);
        read_all();

        // Read addr 5, drop en and move addr: dout must hold.
        en = 1'b1; addr = 4'd5; exp_q.push_back(model[5]);
        @(posedge clk); #1;
        en = 1'b0; addr = 4'd7;
        @(posedge clk); #1;
        check("dout_hold", int'(dout), int'(model[5]));
        @(posedge clk); #1;
        check("dout_hold2", int'(dout), int'(model[5]));

        // Random image with a start pulse mid-load and stall gaps.
        for (int i = 0; i < 16; i++) img[i] = 5'($urandom);
        load(2, 23, 80);
        read_all();

        // Random prior image, then partial load (3 words + 2 bits) abandoned by reset.
        for (int i = 0; i < 16; i++) img[i] = 5'($urandom);
        img[15] = img[15] | 5'b00001;
        load(1, -1, 80);
        read_all();
        for (int i = 0; i < 16; i++) img[i] = 5'($urandom);
        load(0, -1, 17);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midload_rst_busy", int'(busy), 0);
        check("midload_rst_dout", int'(dout), 0);
        check("midload_rst_ready", int'(sin_ready), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) model[i] = img[i];
        read_all();

        // Reload with all ones.
        for (int i = 0; i < 16; i++) img[i] = 5'b11111;
        load(0, -1, 80);
        read_all();

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) check("rd_pending", exp_q.size(), 0);
        if (done_q.size() != 0) check("done_pending", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rom_loader
